parity_rr_sched: RTL and testbench
==================================

Name: parity_rr_sched

Overview:
Shares one registered 8-bit parity engine among NREQ requesters.
- Round-robin arbitration between requesters.
- Valid/ready handshake on both request and result sides.
- Each result is tagged with the requester index so the downstream consumer can route it.
- Sits between the byte sources (UART TX lanes, packet framers) and the parity datapath.

Parameters:
NREQ, 4, number of requesters (2..16)
DW, 8, data width per request
ODD, 0, 0 = even parity (XOR of all bits); 1 = odd parity (inverted XOR)
CW, 16, width of the result counter

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_data  in  NREQ*DW  packed request data; requester k occupies bits [k*DW +: DW]
req_ready  out  NREQ  per-requester accept, at most one bit high
res_valid  out  1  result valid
res_par  out  1  parity of the granted word
res_id  out  clog2(NREQ)  index of the requester that produced res_par
res_ready  in  1  downstream accepts result
busy  out  1  high whenever state != IDLE
res_cnt  out  CW  count of accepted results, wraps at 2^CW

Behaviour:
- Clock is clk. Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE
  - rr_ptr = 0
  - res_valid = 0, res_par = 0, res_id = 0
  - res_cnt = 0, busy = 0
  - req_ready is all-zero while rst_n is low.
- FSM has three states: IDLE, CALC, HOLD.
- IDLE:
  - Select the grant g as the first k with req_valid[k]=1, searching from rr_ptr upward modulo NREQ.
  - req_ready[g] is driven combinationally high in the same cycle; a transfer occurs.
  - On the clock edge: latch req_data[g] and g into the engine input registers; go to CALC.
  - No valid request: remain in IDLE, req_ready = 0.
- CALC:
  - The engine XOR-reduces the latched word; ODD=1 inverts the result.
  - On the edge: register res_par and res_id, set res_valid = 1, go to HOLD.
  - req_ready = 0.
- HOLD:
  - res_valid, res_par and res_id are held stable until res_valid && res_ready.
  - On accept, in the same edge:
    - res_valid -> 0
    - rr_ptr -> (res_id+1) mod NREQ
    - res_cnt increments
    - go to IDLE
  - req_ready = 0.
- Latency: transfer in cycle T gives res_valid high in cycle T+2. Peak throughput is 1 result per 3 cycles.
- Requesters must hold req_valid/req_data until their req_ready. Deasserting req_valid in IDLE with no grant is legal and has no effect.
- Simultaneous requests: only one grant per IDLE cycle. Losers keep waiting. No requester waits more than NREQ grants.
- rr_ptr wrap: when res_id = NREQ-1, the pointer goes to 0.
- res_cnt wraps from 2^CW-1 to 0 silently.
- Reset asserted in CALC or HOLD: the in-flight transaction is discarded, no result is emitted, and all state returns to reset values on that edge.
- res_ready high outside HOLD is ignored.

Decomposition:
- Shared package parity_pkg holds:
  - PAR_EVEN / PAR_ODD constants
  - the state enum typedef (IDLE, CALC, HOLD)
  - an id-width function clog2
- One sub-module, parity_engine:
  - DW-bit registered XOR reduction with an ODD parameter.
  - Inputs: clk, rst_n, load, din. Output: par.
  - Reusable by other parity clients.
- The round-robin arbiter stays inline in parity_rr_sched.

Test Plan:
- Single request, requester 0, data 0x07, res_ready=1 -> req_ready[0] pulses in cycle T; res_valid=1, res_par=1, res_id=0 in T+2; res_cnt=1.
- All four requesters valid at once with 0x00, 0x01, 0x03, 0xFF -> results in order id 0,1,2,3 with par 0,1,0,0, each 3 cycles apart; res_cnt=4.
- Backpressure: res_ready held low 5 cycles in HOLD -> res_valid/res_par/res_id stable for the whole stall; no req_ready asserted; accept on cycle 6 returns the FSM to IDLE.
- Fairness: req0 and req2 continuously valid for 6 grants -> grant order 0,2,0,2,0,2; req1 and req3 never granted.
- Reset mid-op: rst_n low during CALC -> next cycle res_valid=0, busy=0, rr_ptr=0, res_cnt unchanged-to-0, and no result appears.
- ODD=1 build: data 0x00 -> res_par=1; data 0x01 -> res_par=0. With NREQ=4, a grant to id 3 followed by a new request from id 0 -> id 0 is granted next (rr_ptr wraps to 0).

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity scheduler and its engine: parity sense
// constants, scheduler state encoding and the requester-id width helper.
package parity_pkg;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Minimum of one bit so a single-bit id port still exists for NREQ=2.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/parity_engine.sv
// Registered DW-bit parity reduction; the result appears one cycle after load.
module parity_engine
  import parity_pkg::*;
#(
  parameter int DW  = 8,
  parameter bit ODD = PAR_EVEN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  output logic          par
);

  logic par_p0;

  // p0: reduced parity of the loaded word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_p0 <= 1'b0;
    end else if (load) begin
      par_p0 <= (^din) ^ ODD;
    end
  end

  assign par = par_p0;

endmodule

// File: rtl/parity_rr_sched.sv
// Round-robin scheduler sharing one parity engine among NREQ requesters,
// with valid/ready on both sides and a requester-tagged result.
module parity_rr_sched
  import parity_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter bit ODD  = PAR_EVEN,
  parameter int CW   = 16,
  localparam int IW  = clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  output logic             res_valid,
  output logic             res_par,
  output logic [IW-1:0]    res_id,
  input  logic             res_ready,
  output logic             busy,
  output logic [CW-1:0]    res_cnt
);

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   grant_id;
  logic [IW:0]     idx;
  logic            grant_vld;
  logic            take;
  logic            accept;
  logic [IW-1:0]   id_p0;
  logic            par_p0;

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (req_valid[idx[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[IW-1:0];
      end
    end
  end

  assign take      = rst_n && (state == IDLE) && grant_vld;
  assign req_ready = take ? (NREQ'(1) << grant_id) : '0;
  assign accept    = (state == HOLD) && res_valid && res_ready;
  assign busy      = (state != IDLE);

  parity_engine #(
    .DW  (DW),
    .ODD (ODD)
  ) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (take),
    .din   (req_data[grant_id*DW +: DW]),
    .par   (par_p0)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take)   state_nxt = CALC;
      CALC:                state_nxt = HOLD;
      HOLD:    if (accept) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // p0: grant tag travels alongside the engine's input word
  always_ff @(posedge clk) begin
    if (take) id_p0 <= grant_id;
  end

  // p1: result register, held until the consumer accepts it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      res_valid <= 1'b0;
      res_par   <= 1'b0;
      res_id    <= '0;
      res_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CALC) begin
        res_valid <= 1'b1;
        res_par   <= par_p0;
        res_id    <= id_p0;
      end
      if (accept) begin
        res_valid <= 1'b0;
        rr_ptr    <= (res_id == IW'(NREQ - 1)) ? '0 : res_id + 1'b1;
        res_cnt   <= res_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_rr_sched.sv
// Scoreboard bench for parity_rr_sched: an even-parity and an odd-parity
// instance share stimulus and are checked against a queue-based reference.
module tb_parity_rr_sched;
  import parity_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int IW   = clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic                res_ready = 1'b0;

  logic [NREQ-1:0]     req_ready, req_ready_o;
  logic                res_valid, res_valid_o;
  logic                res_par, res_par_o;
  logic [IW-1:0]       res_id, res_id_o;
  logic                busy, busy_o;
  logic [CW-1:0]       res_cnt, res_cnt_o;

  always #5 clk = ~clk;

  parity_rr_sched #(.NREQ(NREQ), .DW(DW), .ODD(1'b0), .CW(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_par(res_par),
    .res_id(res_id), .res_ready(res_ready), .busy(busy), .res_cnt(res_cnt)
  );

  parity_rr_sched #(.NREQ(NREQ), .DW(DW), .ODD(1'b1), .CW(CW)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready_o), .res_valid(res_valid_o), .res_par(res_par_o),
    .res_id(res_id_o), .res_ready(res_ready), .busy(busy_o), .res_cnt(res_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = free, 1 = computing, 2 = result presented.
  typedef struct {
    int             id;
    logic [DW-1:0]  data;
  } item_t;

  item_t            exp_q[$];
  int               grant_log[$];
  int               m_phase = 0;
  int               m_ptr = 0;
  int               m_cnt = 0;
  logic [NREQ-1:0]  xfer_vec = '0;
  bit               acc_now = 1'b0;
  int               acc_id = 0;

  // Stimulus-side model: predict the grant and enqueue the expected result.
  initial forever begin
    logic [NREQ-1:0] er;
    int g, k;
    @(negedge clk);
    er = '0;
    g  = -1;
    if (rst_n && m_phase == 0) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (g < 0 && req_valid[k]) g = k;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("req_ready_odd", req_ready_o, er);
    xfer_vec = er;
    if (g >= 0) begin
      exp_q.push_back('{id: g, data: req_data[g*DW +: DW]});
      grant_log.push_back(g);
    end
  end

  // Monitor: compare presented results against the queue head.
  initial forever begin
    bit ev;
    @(negedge clk);
    ev = (m_phase == 2);
    chk("res_valid", res_valid, ev);
    chk("busy", busy, m_phase != 0);
    chk("res_cnt", res_cnt, m_cnt);
    chk("odd_ctrl", {res_valid_o, busy_o, res_cnt_o, res_id_o},
        {res_valid, busy, res_cnt, res_id});
    acc_now = 1'b0;
    if (res_valid) begin
      chk("result_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        chk("res_id", res_id, exp_q[0].id);
        chk("res_par_even", res_par, ^exp_q[0].data);
        chk("res_par_odd", res_par_o, ~^exp_q[0].data);
        if (res_ready && rst_n && m_phase == 2) begin
          acc_now = 1'b1;
          acc_id  = exp_q[0].id;
          exp_q.pop_front();
        end
      end
    end
  end

  // Model time advance at each active edge.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (xfer_vec != '0) m_phase = 1;
        1: m_phase = 2;
        default: if (acc_now) begin
          m_phase = 0;
          m_cnt   = (m_cnt + 1) % (1 << CW);
          m_ptr   = (acc_id + 1) % NREQ;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_outputs", {res_valid, res_par, res_id, busy, res_cnt}, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    grant_log.delete();
  endtask

  task automatic send(input logic [NREQ-1:0] mask, input logic [NREQ*DW-1:0] data);
    logic [NREQ-1:0] pend;
    int n;
    req_data  = data;
    req_valid = req_valid | mask;
    pend      = mask;
    n         = 0;
    while (pend != '0 && n < 200) begin
      tick();
      pend      = pend & ~xfer_vec;
      req_valid = req_valid & ~xfer_vec;
      n++;
    end
    chk("send_timeout", pend, 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_valid != '0 || m_phase != 0) && n < 200) begin
      tick();
      req_valid = req_valid & ~xfer_vec;
      n++;
    end
    chk("drain_timeout", (req_valid != '0) || (m_phase != 0), 0);
  endtask

  initial begin
    int exp_fair[6];
    int exp_four[4];
    int exp_wrap[3];
    int n;
    logic [IW:0] held_id;
    logic held_par;

    exp_fair = '{0, 2, 0, 2, 0, 2};
    exp_four = '{0, 1, 2, 3};
    exp_wrap = '{3, 0, 3};

    // Single request, requester 0, 0x07
    do_reset();
    res_ready = 1'b1;
    send(4'b0001, {8'h00, 8'h00, 8'h00, 8'h07});
    drain();
    chk("single_cnt", res_cnt, 1);
    chk("single_log_size", grant_log.size(), 1);

    // All four at once
    do_reset();
    res_ready = 1'b1;
    send(4'b1111, {8'hFF, 8'h03, 8'h01, 8'h00});
    drain();
    chk("four_cnt", res_cnt, 4);
    chk("four_log_size", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("four_order", grant_log[i], exp_four[i]);

    // Backpressure: five stalled cycles in HOLD, a competing request waits
    do_reset();
    res_ready = 1'b0;
    send(4'b0010, {8'h00, 8'h00, 8'h5A, 8'h00});
    n = 0;
    while (!res_valid && n < 20) begin tick(); n++; end
    chk("bp_res_valid", res_valid, 1);
    held_id  = {1'b0, res_id};
    held_par = res_par;
    req_data[0 +: DW] = 8'h81;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stable", {res_valid, res_par, 1'b0, res_id}, {1'b1, held_par, held_id});
    end
    res_ready = 1'b1;
    tick();
    chk("bp_release", {res_valid, busy}, 2'b00);
    drain();
    chk("bp_cnt", res_cnt, 2);

    // Fairness: requesters 0 and 2 continuously valid
    do_reset();
    res_ready = 1'b1;
    req_valid = 4'b0101;
    n = 0;
    while (grant_log.size() < 6 && n < 100) begin
      tick();
      for (int k = 0; k < NREQ; k++)
        if (xfer_vec[k]) req_data[k*DW +: DW] = DW'($urandom);
      n++;
    end
    req_valid = '0;
    drain();
    chk("fair_log_size", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("fair_order", grant_log[i], exp_fair[i]);

    // Reset while the engine is computing
    do_reset();
    res_ready = 1'b1;
    send(4'b0001, {8'h00, 8'h00, 8'h00, 8'h07});
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_after", {res_valid, busy, res_cnt}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_no_result", res_cnt, 0);

    // Pointer wrap after id 3
    do_reset();
    res_ready = 1'b1;
    send(4'b1000, {8'hC3, 8'h00, 8'h00, 8'h00});
    drain();
    send(4'b1001, {8'h7F, 8'h00, 8'h00, 8'h01});
    drain();
    chk("wrap_log_size", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) chk("wrap_order", grant_log[i], exp_wrap[i]);

    // Randomized traffic with random backpressure
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NREQ; k++) begin
        if (xfer_vec[k] && req_valid[k]) begin
          req_valid[k] = $urandom_range(0, 1);
          req_data[k*DW +: DW] = DW'($urandom);
        end else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          req_valid[k] = 1'b1;
          req_data[k*DW +: DW] = DW'($urandom);
        end
      end
      tick();
    end
    req_valid = '0;
    res_ready = 1'b1;
    drain();
    chk("random_cnt_model", res_cnt, m_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
